morra_cinese_param: RTL and testbench



---
 rtl/morra_pkg.sv | 47 ++++
 rtl/morra_round_judge.sv | 43 ++++
 rtl/morra_cinese_param.sv | 154 +++++++++++++++
 tb/tb_morra_cinese_param.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/morra_pkg.sv
// Shared types and helpers for the parametrised MorraCinese game.
//   move_t  : 2-bit player move (00 invalid, 01 rock, 10 paper, 11 scissors)
//   rres_t  : per-round result
//   gres_t  : game result
//   state_t : game FSM state
//   prev_t  : previous-round winner memory (used only when MORRA_NOREPEAT_EN is defined)
//   beats() : 1 when move a defeats move b
package morra_pkg;

  typedef enum logic [1:0] {
    MV_NONE     = 2'b00,
    MV_ROCK     = 2'b01,
    MV_PAPER    = 2'b10,
    MV_SCISSORS = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    R_NONE = 2'b00,
    R_P1   = 2'b01,
    R_P2   = 2'b10,
    R_TIE  = 2'b11
  } rres_t;

  typedef enum logic [1:0] {
    G_NONE = 2'b00,
    G_P1   = 2'b01,
    G_P2   = 2'b10,
    G_DRAW = 2'b11
  } gres_t;

  typedef enum logic [0:0] {
    S_PLAY = 1'b0,
    S_IDLE = 1'b1
  } state_t;

  typedef struct packed {
    rres_t winner;
    move_t move;
  } prev_t;

  function automatic logic beats(move_t a, move_t b);
    return ((a == MV_ROCK)     && (b == MV_SCISSORS)) ||
           ((a == MV_SCISSORS) && (b == MV_PAPER))    ||
           ((a == MV_PAPER)    && (b == MV_ROCK));
  endfunction

endpackage

// File: rtl/morra_round_judge.sv
// Combinational round judge: scores one pair of moves.
// Ports:
//   p1, p2 : player moves
//   prev   : previous-winner memory (present only with MORRA_NOREPEAT_EN)
//   res    : round result (R_NONE when the round is invalid)
//   valid  : 1 when the round counts
// Macro MORRA_NOREPEAT_EN: forbids the previous winner from replaying its winning move.
module morra_round_judge
  import morra_pkg::*;
(
  input  move_t p1,
  input  move_t p2,
`ifdef MORRA_NOREPEAT_EN
  input  prev_t prev,
`endif
  output rres_t res,
  output logic  valid
);

  logic rep_hit;

  // Round validity and winner selection
  always_comb begin
    res     = R_NONE;
    valid   = 1'b0;
    rep_hit = 1'b0;
`ifdef MORRA_NOREPEAT_EN
    rep_hit = ((prev.winner == R_P1) && (p1 == prev.move)) ||
              ((prev.winner == R_P2) && (p2 == prev.move));
`endif
    if ((p1 != MV_NONE) && (p2 != MV_NONE) && !rep_hit) begin
      valid = 1'b1;
      if (p1 == p2) begin
        res = R_TIE;
      end else if (beats(p1, p2)) begin
        res = R_P1;
      end else begin
        res = R_P2;
      end
    end
  end

endmodule

// File: rtl/morra_cinese_param.sv
// Parametrised two-player rock-paper-scissors game FSMD.
// One round is sampled per clock; all outputs are registered (latency 1).
// Ports:
//   clk       : clock, rising edge
//   START     : synchronous active-high reset / new game; latches max rounds from {P1,P2}
//   P1, P2    : player moves (configuration field while START=1)
//   ROUND     : last round result
//   GAME      : game result, pulses for one cycle at game end
//   ROUND_CNT : valid rounds played in the current game
//   LEAD      : signed score difference P1 - P2
//   BUSY      : 1 while a game is in progress
// Macro MORRA_NOREPEAT_EN: enables the no-repeat rule for the previous round winner.
module morra_cinese_param
  import morra_pkg::*;
#(
  parameter int unsigned MIN_ROUNDS = 4,
  parameter int unsigned WIN_LEAD   = 2,
  parameter int unsigned CNT_W      = 5
) (
  input  logic                    clk,
  input  logic                    START,
  input  logic [1:0]              P1,
  input  logic [1:0]              P2,
  output logic [1:0]              ROUND,
  output logic [1:0]              GAME,
  output logic [CNT_W-1:0]        ROUND_CNT,
  output logic signed [CNT_W:0]   LEAD,
  output logic                    BUSY
);

  localparam int unsigned LEAD_W = CNT_W + 1;

  // The counter must reach MIN_ROUNDS + 15 (largest configurable max)
  if ((MIN_ROUNDS + 15) >= (1 << CNT_W)) begin : g_cnt_w_check
    $error("morra_cinese_param: CNT_W too small for MIN_ROUNDS + 15");
  end

  state_t                    state;
  state_t                    state_nxt;
  logic [CNT_W-1:0]          max_rounds;
  rres_t                     judge_res;
  logic                      judge_valid;
  rres_t                     round_nxt;
  gres_t                     game_nxt;
  logic [CNT_W-1:0]          cnt_nxt;
  logic [CNT_W-1:0]          cnt_upd;
  logic signed [LEAD_W-1:0]  lead_nxt;
  logic signed [LEAD_W-1:0]  lead_upd;
  logic [LEAD_W-1:0]         lead_abs;
  logic                      busy_nxt;
  logic                      game_end;

`ifdef MORRA_NOREPEAT_EN
  prev_t prev_win;
  prev_t prev_nxt;
`endif

  morra_round_judge u_judge (
    .p1    (move_t'(P1)),
    .p2    (move_t'(P2)),
`ifdef MORRA_NOREPEAT_EN
    .prev  (prev_win),
`endif
    .res   (judge_res),
    .valid (judge_valid)
  );

  // Next-state, counter update and end-of-game decision
  always_comb begin
    state_nxt = state;
    round_nxt = R_NONE;
    game_nxt  = G_NONE;
    cnt_nxt   = ROUND_CNT;
    lead_nxt  = LEAD;
    busy_nxt  = 1'b0;
`ifdef MORRA_NOREPEAT_EN
    prev_nxt  = prev_win;
`endif

    cnt_upd  = ROUND_CNT + CNT_W'(1);
    lead_upd = LEAD;
    if (judge_res == R_P1) begin
      lead_upd = LEAD + LEAD_W'(1);
    end else if (judge_res == R_P2) begin
      lead_upd = LEAD - LEAD_W'(1);
    end
    lead_abs = $unsigned(lead_upd[LEAD_W-1] ? -lead_upd : lead_upd);

    // End test uses the values this round would produce
    game_end = ((cnt_upd >= CNT_W'(MIN_ROUNDS)) && (lead_abs >= LEAD_W'(WIN_LEAD))) ||
               (cnt_upd == max_rounds);

    case (state)
      S_PLAY: begin
        busy_nxt = 1'b1;
        if (judge_valid) begin
          round_nxt = judge_res;
          cnt_nxt   = cnt_upd;
          lead_nxt  = lead_upd;
`ifdef MORRA_NOREPEAT_EN
          if (judge_res == R_TIE) begin
            prev_nxt = prev_t'{winner: R_NONE, move: MV_NONE};
          end else if (judge_res == R_P1) begin
            prev_nxt = prev_t'{winner: R_P1, move: move_t'(P1)};
          end else begin
            prev_nxt = prev_t'{winner: R_P2, move: move_t'(P2)};
          end
`endif
          if (game_end) begin
            busy_nxt  = 1'b0;
            state_nxt = S_IDLE;
            if (lead_upd[LEAD_W-1]) begin
              game_nxt = G_P2;
            end else if (lead_upd != '0) begin
              game_nxt = G_P1;
            end else begin
              game_nxt = G_DRAW;
            end
          end
        end
      end
      default: begin
        busy_nxt = 1'b0;
      end
    endcase
  end

  // State and output registers; START restarts the game and latches the round limit
  always_ff @(posedge clk) begin
    if (START) begin
      state      <= S_PLAY;
      ROUND      <= '0;
      GAME       <= '0;
      ROUND_CNT  <= '0;
      LEAD       <= '0;
      BUSY       <= 1'b1;
      max_rounds <= CNT_W'(MIN_ROUNDS) + CNT_W'({P1, P2});
`ifdef MORRA_NOREPEAT_EN
      prev_win   <= prev_t'{winner: R_NONE, move: MV_NONE};
`endif
    end else begin
      state      <= state_nxt;
      ROUND      <= round_nxt;
      GAME       <= game_nxt;
      ROUND_CNT  <= cnt_nxt;
      LEAD       <= lead_nxt;
      BUSY       <= busy_nxt;
`ifdef MORRA_NOREPEAT_EN
      prev_win   <= prev_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_morra_cinese_param.sv
// Self-checking bench for morra_cinese_param: directed scenarios plus random play,
// checked against an arithmetic reference model of the game rules.
module tb_morra_cinese_param;

  localparam int unsigned CW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 START, start2;
  logic [1:0]           P1, P2, p1_2, p2_2;
  logic [1:0]           ROUND, GAME, round2, game2;
  logic [CW-1:0]        ROUND_CNT, cnt2;
  logic signed [CW:0]   LEAD, lead2;
  logic                 BUSY, busy2;

  int n_cmp  = 0;
  int n_fail = 0;

  morra_cinese_param dut (
    .clk(clk), .START(START), .P1(P1), .P2(P2),
    .ROUND(ROUND), .GAME(GAME), .ROUND_CNT(ROUND_CNT), .LEAD(LEAD), .BUSY(BUSY)
  );

  morra_cinese_param #(.MIN_ROUNDS(2), .WIN_LEAD(1), .CNT_W(5)) dut2 (
    .clk(clk), .START(start2), .P1(p1_2), .P2(p2_2),
    .ROUND(round2), .GAME(game2), .ROUND_CNT(cnt2), .LEAD(lead2), .BUSY(busy2)
  );

  // Reference model: game status plus the outputs expected after one edge
  typedef struct {
    int busy;
    int cnt;
    int lead;
    int maxr;
    int pw;
    int pm;
    int e_round;
    int e_game;
  } mdl_t;

  mdl_t m, m2;

  function automatic mdl_t step(mdl_t cur, bit st, int a, int b, int minr, int winl);
    mdl_t n;
    bit   ok;
    int   d, mag;
    n = cur;
    n.e_round = 0;
    n.e_game  = 0;
    if (st) begin
      n.busy = 1; n.cnt = 0; n.lead = 0;
      n.maxr = minr + a * 4 + b;
      n.pw = 0; n.pm = 0;
      return n;
    end
    if (cur.busy == 0) return n;
    ok = (a != 0) && (b != 0);
`ifdef MORRA_NOREPEAT_EN
    if ((cur.pw == 1 && a == cur.pm) || (cur.pw == 2 && b == cur.pm)) ok = 1'b0;
`endif
    if (!ok) return n;
    // rock=1, paper=2, scissors=3: the mover one step ahead modulo 3 wins
    d = (a - b + 3) % 3;
    n.cnt = cur.cnt + 1;
    if (d == 0) begin
      n.e_round = 3; n.pw = 0; n.pm = 0;
    end else if (d == 1) begin
      n.e_round = 1; n.lead = cur.lead + 1; n.pw = 1; n.pm = a;
    end else begin
      n.e_round = 2; n.lead = cur.lead - 1; n.pw = 2; n.pm = b;
    end
    mag = (n.lead < 0) ? -n.lead : n.lead;
    if ((n.cnt >= minr && mag >= winl) || n.cnt == n.maxr) begin
      n.e_game = (n.lead > 0) ? 1 : ((n.lead < 0) ? 2 : 3);
      n.busy = 0;
    end
    return n;
  endfunction

  function automatic logic [15:0] expv(mdl_t x);
    return {2'(x.e_round), 2'(x.e_game), 5'(x.cnt), 6'(x.lead), 1'(x.busy)};
  endfunction

  task automatic apply(bit st, int a, int b);
    @(negedge clk);
    START = st; P1 = 2'(a); P2 = 2'(b);
    @(posedge clk);
    m = step(m, st, a, b, 4, 2);
    #1;
  endtask

  task automatic apply2(bit st, int a, int b);
    @(negedge clk);
    start2 = st; p1_2 = 2'(a); p2_2 = 2'(b);
    @(posedge clk);
    m2 = step(m2, st, a, b, 2, 1);
    #1;
  endtask

  task automatic test_reset();
    apply(1, 0, 0);
    n_cmp++;
    if ({ROUND, GAME, ROUND_CNT, LEAD, BUSY} !== 16'h0001) begin
      n_fail++;
      $display("FAIL reset: got %h want %h", {ROUND, GAME, ROUND_CNT, LEAD, BUSY}, 16'h0001);
    end
    apply(1, 3, 3);
    apply(0, 1, 1);
    n_cmp++;
    if ({ROUND, GAME, ROUND_CNT, LEAD, BUSY} !== expv(m)) begin
      n_fail++;
      $display("FAIL reset_tie: got %h want %h", {ROUND, GAME, ROUND_CNT, LEAD, BUSY}, expv(m));
    end
  endtask

  task automatic test_plan_seq();
    int s1[6] = '{0, 1, 1, 2, 3, 1};
    int s2[6] = '{0, 3, 2, 1, 2, 3};
    int want_lead;
    for (int i = 0; i < 6; i++) begin
      apply(i == 0, s1[i], s2[i]);
      n_cmp++;
      if ({ROUND, GAME, ROUND_CNT, LEAD, BUSY} !== expv(m)) begin
        n_fail++;
        $display("FAIL plan step %0d: got %h want %h", i, {ROUND, GAME, ROUND_CNT, LEAD, BUSY}, expv(m));
      end
    end
`ifdef MORRA_NOREPEAT_EN
    want_lead = 4;
`else
    want_lead = 2;
`endif
    n_cmp++;
    if (ROUND_CNT !== 5'd4 || int'(LEAD) != want_lead || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL plan_final: cnt=%0d lead=%0d busy=%0d want 4 %0d 0", ROUND_CNT, LEAD, BUSY, want_lead);
    end
  endtask

  task automatic test_ties();
    int s1[8] = '{0, 1, 2, 3, 0, 1, 3, 2};
    int s2[8] = '{0, 1, 2, 3, 0, 2, 0, 1};
    for (int i = 0; i < 8; i++) begin
      apply(i == 0, s1[i], s2[i]);
      n_cmp++;
      if ({ROUND, GAME, ROUND_CNT, LEAD, BUSY} !== expv(m)) begin
        n_fail++;
        $display("FAIL ties step %0d: got %h want %h", i, {ROUND, GAME, ROUND_CNT, LEAD, BUSY}, expv(m));
      end
    end
  endtask

  task automatic test_max_rounds();
    apply(1, 3, 3);
    for (int r = 1; r <= 19; r++) begin
      if (r == 19) apply(0, 2, 2);
      else if (r % 2 == 1) apply(0, 1, 3);
      else apply(0, 3, 1);
      n_cmp++;
      if ({ROUND, GAME, ROUND_CNT, LEAD, BUSY} !== expv(m)) begin
        n_fail++;
        $display("FAIL max round %0d: got %h want %h", r, {ROUND, GAME, ROUND_CNT, LEAD, BUSY}, expv(m));
      end
    end
    n_cmp++;
    if (GAME !== 2'b11 || ROUND_CNT !== 5'd19 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL max_final: game=%0d cnt=%0d busy=%0d want 3 19 0", GAME, ROUND_CNT, BUSY);
    end
  endtask

  task automatic test_midgame_start();
    int k;
    apply(1, 1, 0);
    apply(0, 1, 3);
    apply(0, 2, 3);
    apply(1, 2, 3);
    n_cmp++;
    if ({ROUND, GAME, ROUND_CNT, LEAD, BUSY} !== 16'h0001) begin
      n_fail++;
      $display("FAIL midgame_start: got %h want %h", {ROUND, GAME, ROUND_CNT, LEAD, BUSY}, 16'h0001);
    end
    k = 0;
    while (m.busy != 0 && k < 80) begin
      apply(0, $urandom_range(0, 3), $urandom_range(0, 3));
      k++;
      n_cmp++;
      if ({ROUND, GAME, ROUND_CNT, LEAD, BUSY} !== expv(m)) begin
        n_fail++;
        $display("FAIL midgame play %0d: got %h want %h", k, {ROUND, GAME, ROUND_CNT, LEAD, BUSY}, expv(m));
      end
    end
    n_cmp++;
    if (m.busy != 0) begin
      n_fail++;
      $display("FAIL midgame_bound: game still running after %0d cycles, want ended", k);
    end
  endtask

  task automatic test_idle_and_restart();
    int k;
    apply(0, 3, 0);
    apply(0, 2, 1);
    n_cmp++;
    if ({ROUND, GAME, ROUND_CNT, LEAD, BUSY} !== expv(m)) begin
      n_fail++;
      $display("FAIL idle_hold: got %h want %h", {ROUND, GAME, ROUND_CNT, LEAD, BUSY}, expv(m));
    end
    apply(1, 0, 0);
    apply(1, 0, 1);
    k = 0;
    while (m.busy != 0 && k < 80) begin
      apply(0, $urandom_range(0, 3), $urandom_range(0, 3));
      k++;
      n_cmp++;
      if ({ROUND, GAME, ROUND_CNT, LEAD, BUSY} !== expv(m) || ROUND_CNT > 5'd5) begin
        n_fail++;
        $display("FAIL restart play %0d: got %h want %h (cnt limit 5)", k, {ROUND, GAME, ROUND_CNT, LEAD, BUSY}, expv(m));
      end
    end
  endtask

  task automatic test_random();
    bit st;
    for (int i = 0; i < 600; i++) begin
      st = ($urandom_range(0, 39) == 0) || (m.busy == 0 && $urandom_range(0, 3) == 0);
      apply(st, $urandom_range(0, 3), $urandom_range(0, 3));
      n_cmp++;
      if ({ROUND, GAME, ROUND_CNT, LEAD, BUSY} !== expv(m)) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %h want %h", i, {ROUND, GAME, ROUND_CNT, LEAD, BUSY}, expv(m));
      end
    end
  endtask

  task automatic test_param_override();
    bit st;
    apply2(1, 0, 0);
    apply2(0, 1, 1);
    apply2(0, 1, 2);
    n_cmp++;
    if (game2 !== 2'b10 || round2 !== 2'b10 || cnt2 !== 5'd2 || lead2 !== -6'sd1 || busy2 !== 1'b0) begin
      n_fail++;
      $display("FAIL param_end: round=%0d game=%0d cnt=%0d lead=%0d busy=%0d want 2 2 2 -1 0",
               round2, game2, cnt2, lead2, busy2);
    end
    for (int i = 0; i < 200; i++) begin
      st = ($urandom_range(0, 29) == 0) || (m2.busy == 0 && $urandom_range(0, 2) == 0);
      apply2(st, $urandom_range(0, 3), $urandom_range(0, 3));
      n_cmp++;
      if ({round2, game2, cnt2, lead2, busy2} !== expv(m2)) begin
        n_fail++;
        $display("FAIL param random %0d: got %h want %h", i, {round2, game2, cnt2, lead2, busy2}, expv(m2));
      end
    end
  endtask

  initial begin
    START = 1'b1; P1 = 2'b00; P2 = 2'b00;
    start2 = 1'b1; p1_2 = 2'b00; p2_2 = 2'b00;
    m  = '{default: 0};
    m2 = '{default: 0};
    test_reset();
    test_plan_seq();
    test_ties();
    test_max_rounds();
    test_midgame_start();
    test_idle_and_restart();
    test_random();
    test_param_override();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
